// File: rtl/div_seq.sv
// Iterative restoring divider for the EX stage: DIV/DIVU over a shared
// WIDTH-bit compare/subtract datapath, returning {remainder, quotient}.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH-1:0] w_trial;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Shared compare/subtract datapath plus operand magnitude and sign fix-up.
  // The partial remainder never carries a set MSB into the shift before the
  // final iteration, so a WIDTH-bit trial value is exact.
  always_comb begin
    w_trial    = {r_rem[WIDTH-2:0], r_dividend[WIDTH-1]};
    w_ge       = (w_trial >= r_divisor);
    w_diff     = w_trial - r_divisor;
    if (signed_div_i && opdata1_i[WIDTH-1]) begin
      w_abs1 = f_neg(opdata1_i);
    end else begin
      w_abs1 = opdata1_i;
    end
    if (signed_div_i && opdata2_i[WIDTH-1]) begin
      w_abs2 = f_neg(opdata2_i);
    end else begin
      w_abs2 = opdata2_i;
    end
    w_quot_fix = r_neg_q ? f_neg(r_quot) : r_quot;
    w_rem_fix  = r_neg_r ? f_neg(r_rem) : r_rem;
  end

  // Sequencer FSM with registered result/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FREE;
      r_cnt      <= {CW{1'b0}};
      r_dividend <= {WIDTH{1'b0}};
      r_divisor  <= {WIDTH{1'b0}};
      r_rem      <= {WIDTH{1'b0}};
      r_quot     <= {WIDTH{1'b0}};
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      result_o   <= {(2*WIDTH){1'b0}};
      ready_o    <= 1'b0;
    end else if (annul_i && (r_state != S_FREE)) begin
      r_state  <= S_FREE;
      result_o <= {(2*WIDTH){1'b0}};
      ready_o  <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          result_o <= {(2*WIDTH){1'b0}};
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == {WIDTH{1'b0}}) begin
              r_state <= S_BYZERO;
            end else begin
              r_state    <= S_ON;
              r_dividend <= w_abs1;
              r_divisor  <= w_abs2;
              r_neg_q    <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              r_neg_r    <= signed_div_i & opdata1_i[WIDTH-1];
              r_rem      <= {WIDTH{1'b0}};
              r_quot     <= {WIDTH{1'b0}};
              r_cnt      <= {CW{1'b0}};
            end
          end
        end
        S_BYZERO: begin
          r_state  <= S_END;
          result_o <= {(2*WIDTH){1'b0}};
          ready_o  <= 1'b1;
        end
        S_ON: begin
          if (r_cnt == CW'(WIDTH)) begin
            r_state  <= S_END;
            result_o <= {w_rem_fix, w_quot_fix};
            ready_o  <= 1'b1;
          end else begin
            r_rem      <= w_ge ? w_diff : w_trial;
            r_quot     <= {r_quot[WIDTH-2:0], w_ge};
            r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
            r_cnt      <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_END: begin
          if (!start_i) begin
            r_state  <= S_FREE;
            result_o <= {(2*WIDTH){1'b0}};
            ready_o  <= 1'b0;
          end else begin
            ready_o <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_FREE;
          result_o <= {(2*WIDTH){1'b0}};
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq; each task checks its own scenario.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks;
  int n_errors;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request at the current negedge; returns edges after E0 until ready.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output int lat);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (scramble && i == 3) begin
        opdata1_i    = 32'hDEADBEEF;
        opdata2_i    = 32'h00000003;
        signed_div_i = ~s;
      end
      if (ready_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd10; opdata2_i = 32'd2;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_errors++;
      $display("FAIL reset: ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    end
    rst = 1'b0; start_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: ready=%b expected 0", ready_o);
    end
  endtask

  task automatic test_unsigned;
    int lat;
    run_div(1'b0, 32'd100, 32'd7, 1'b0, lat);
    n_checks++;
    if (lat !== 33) begin
      n_errors++;
      $display("FAIL u100_7_latency: got %0d expected 33", lat);
    end
    n_checks++;
    if (result_o !== {32'd2, 32'd14}) begin
      n_errors++;
      $display("FAIL u100_7_result: got %h expected %h", result_o, {32'd2, 32'd14});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14}) begin
      n_errors++;
      $display("FAIL u100_7_hold: ready=%b result=%h expected ready=1 result=%h",
               ready_o, result_o, {32'd2, 32'd14});
    end
    start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_errors++;
      $display("FAIL u100_7_release: ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    end
  endtask

  task automatic test_signed;
    logic [31:0] a_tab [3];
    logic [31:0] b_tab [3];
    logic [63:0] e_tab [3];
    int lat;
    a_tab[0] = 32'hFFFFFFF9; b_tab[0] = 32'd2;        e_tab[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
    a_tab[1] = 32'd7;        b_tab[1] = 32'hFFFFFFFE; e_tab[1] = {32'd1, 32'hFFFFFFFD};
    a_tab[2] = 32'hFFFFFF9C; b_tab[2] = 32'hFFFFFFF9; e_tab[2] = {32'hFFFFFFFE, 32'd14};
    for (int k = 0; k < 3; k++) begin
      run_div(1'b1, a_tab[k], b_tab[k], 1'b0, lat);
      n_checks++;
      if (lat !== 33 || result_o !== e_tab[k]) begin
        n_errors++;
        $display("FAIL signed_%0d: lat=%0d result=%h expected lat=33 result=%h",
                 k, lat, result_o, e_tab[k]);
      end
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_divzero;
    int lat;
    run_div(1'b0, 32'h12345678, 32'd0, 1'b0, lat);
    n_checks++;
    if (lat !== 1 || result_o !== 64'd0) begin
      n_errors++;
      $display("FAIL divzero_u: lat=%0d result=%h expected lat=1 result=0", lat, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL divzero_release: ready=%b expected 0", ready_o);
    end
    run_div(1'b1, 32'hFFFFFFFB, 32'd0, 1'b0, lat);
    n_checks++;
    if (lat !== 1 || result_o !== 64'd0) begin
      n_errors++;
      $display("FAIL divzero_s: lat=%0d result=%h expected lat=1 result=0", lat, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_boundary;
    int lat;
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat);
    n_checks++;
    if (result_o !== {32'd0, 32'h80000000}) begin
      n_errors++;
      $display("FAIL overflow: got %h expected %h", result_o, {32'd0, 32'h80000000});
    end
    start_i = 1'b0;
    @(negedge clk);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, lat);
    n_checks++;
    if (result_o !== {32'd0, 32'hFFFFFFFF}) begin
      n_errors++;
      $display("FAIL umax_1: got %h expected %h", result_o, {32'd0, 32'hFFFFFFFF});
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    run_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, lat);
    n_checks++;
    if (lat !== 33 || result_o !== {32'd1, 32'd1}) begin
      n_errors++;
      $display("FAIL b2b: lat=%0d result=%h expected lat=33 result=%h", lat, result_o, {32'd1, 32'd1});
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_annul;
    int lat;
    bit seen;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        annul_i = 1'b1;
        start_i = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_errors++;
      $display("FAIL annul: ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    end
    annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_errors++;
      $display("FAIL annul_quiet: ready seen=%b expected 0", seen);
    end
    run_div(1'b0, 32'd9, 32'd3, 1'b0, lat);
    n_checks++;
    if (lat !== 33 || result_o !== {32'd0, 32'd3}) begin
      n_errors++;
      $display("FAIL after_annul: lat=%0d result=%h expected lat=33 result=%h", lat, result_o, {32'd0, 32'd3});
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    int lat;
    signed_div_i = 1'b0; opdata1_i = 32'd7777; opdata2_i = 32'd7; start_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 19) rst = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_errors++;
      $display("FAIL rst_mid: ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    end
    rst = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    run_div(1'b0, 32'd50, 32'd5, 1'b1, lat);
    n_checks++;
    if (lat !== 33 || result_o !== {32'd0, 32'd10}) begin
      n_errors++;
      $display("FAIL after_rst_scramble: lat=%0d result=%h expected lat=33 result=%h",
               lat, result_o, {32'd0, 32'd10});
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_boundary();
    test_back_to_back();
    test_annul();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
